// File: rtl/ucode_mul_shiftadd_if.sv
// ucode_mul_shiftadd_if: ID-side start/operand bus and injected-op/strobe bus of the MUL sequencer
interface ucode_mul_shiftadd_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
);
    logic              start_mul;
    logic [1:0]        mul_type;
    logic [3:0]        dest_reg;
    logic [3:0]        source_reg;
    logic [IMM_W-1:0]  immediate;
    logic [DATA_W-1:0] readDataSecond;
    logic [3:0]        flags_in;
    logic              stall;
    logic              flush;
    logic [31:0]       output_instruction;
    logic              mux_ctrl;
    logic              busy;
    logic              mul_release;
    logic [3:0]        flags_back_out;
    logic              flags_restore;
    logic              mul_err;
    modport master (
        output start_mul, mul_type, dest_reg, source_reg, immediate, readDataSecond, flags_in, stall, flush,
        input  output_instruction, mux_ctrl, busy, mul_release, flags_back_out, flags_restore, mul_err
    );
    modport slave (
        input  start_mul, mul_type, dest_reg, source_reg, immediate, readDataSecond, flags_in, stall, flush,
        output output_instruction, mux_ctrl, busy, mul_release, flags_back_out, flags_restore, mul_err
    );
endinterface

// File: rtl/ucode_mul_shiftadd.sv
// ucode_mul_shiftadd: microcode MUL sequencer injecting a logarithmic shift-and-add op stream
module ucode_mul_shiftadd #(
    parameter int         DATA_W      = 32,
    parameter int         IMM_W       = 16,
    parameter logic [3:0] SCRATCH_REG = 4'd15
) (
    input logic                clk,
    input logic                rst,
    ucode_mul_shiftadd_if.slave bus
);
    typedef enum logic [3:0] {IDLE, CLR_S, CPY, CLR_D, BIT, DBL, NEG1, NEG2, FLG1, FLG2, DONE} state_t;
    localparam logic [31:0] NOP = {5'b11001, 27'b0};
    localparam logic [3:0]  S   = SCRATCH_REG;

    state_t            state_q, state_d, fin;
    logic [DATA_W-1:0] mag_q, mag_d, m, mag_in;
    logic [1:0]        type_q, type_d;
    logic [3:0]        rd_q, rd_d, rs_q, rs_d, flags_q, flags_d;
    logic              neg_q, neg_d, err_q, err_d;
    logic [31:0]       op;

    function automatic logic [31:0] alu3(input logic [6:0] opc, input logic [3:0] a, b, c);
        return {opc, a, b, c, 13'b0};
    endfunction

    // next state: operand capture on start, loop over magnitude bits, flush beats stall
    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        type_d  = type_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        flags_d = flags_q;
        neg_d   = neg_q;
        err_d   = 1'b0;
        m       = bus.mul_type[0] ? bus.readDataSecond
                                  : {{(DATA_W-IMM_W){bus.immediate[IMM_W-1]}}, bus.immediate};
        mag_in  = m[DATA_W-1] ? -m : m;
        fin     = neg_q ? NEG1 : type_q[1] ? FLG1 : DONE;
        if (bus.flush) begin
            state_d = IDLE;
        end else if (!bus.stall) begin
            case (state_q)
                IDLE: if (bus.start_mul) begin
                    if (bus.dest_reg == S || bus.source_reg == S) begin
                        err_d = 1'b1;
                    end else begin
                        type_d  = bus.mul_type;
                        rd_d    = bus.dest_reg;
                        rs_d    = bus.source_reg;
                        flags_d = bus.flags_in;
                        neg_d   = m[DATA_W-1];
                        mag_d   = mag_in;
                        state_d = (mag_in != '0) ? CLR_S : CLR_D;
                    end
                end
                CLR_S: state_d = CPY;
                CPY:   state_d = CLR_D;
                CLR_D: state_d = (mag_q != '0) ? BIT : fin;
                BIT: begin
                    mag_d   = mag_q >> 1;
                    state_d = !mag_q[0] ? BIT : (mag_q[DATA_W-1:1] != '0) ? DBL : fin;
                end
                DBL:   state_d = BIT;
                NEG1:  state_d = NEG2;
                NEG2:  state_d = type_q[1] ? FLG1 : DONE;
                FLG1:  state_d = FLG2;
                FLG2:  state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // op injected in the current slot, a pure function of state and latched operands
    always_comb begin
        op = NOP;
        case (state_q)
            CLR_S: op = {7'b0000000, S, 21'b0};
            CPY:   op = alu3(7'b0110001, S, S, rs_q);
            CLR_D: op = {7'b0000000, rd_q, 21'b0};
            BIT:   op = mag_q[0] ? alu3(7'b0110001, rd_q, rd_q, S) : alu3(7'b0110001, S, S, S);
            DBL:   op = alu3(7'b0110001, S, S, S);
            NEG1:  op = {7'b0010010, rd_q, rd_q, 1'b0, 16'd1};
            NEG2:  op = {7'b0110110, rd_q, rd_q, 17'b0};
            FLG1:  op = alu3(7'b0110010, S, S, S);
            FLG2:  op = alu3(7'b0111001, rd_q, rd_q, S);
            default: op = NOP;
        endcase
    end

    assign bus.output_instruction = op;
    assign bus.mux_ctrl           = state_q != IDLE;
    assign bus.busy               = state_q != IDLE;
    assign bus.mul_release        = state_q == DONE;
    assign bus.flags_restore      = state_q == DONE && !type_q[1];
    assign bus.flags_back_out     = bus.flags_restore ? flags_q : 4'b0;
    assign bus.mul_err            = err_q;

    // state and operand registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            type_q  <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            flags_q <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            type_q  <= type_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
            flags_q <= flags_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_ucode_mul_shiftadd.sv
// tb_ucode_mul_shiftadd: directed checks of the MUL sequencer with a tiny op executor
module tb_ucode_mul_shiftadd;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] rf [16];
    logic nf, zf;
    logic [31:0] ops [128];
    int nops;
    logic rel, fr;
    logic [3:0] fb;

    ucode_mul_shiftadd_if #(.DATA_W(32), .IMM_W(16)) bus ();
    ucode_mul_shiftadd dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'hC800_0000;

    function automatic logic [31:0] f_add(input logic [3:0] d, n, m);
        return {7'b0110001, d, n, m, 13'b0};
    endfunction
    function automatic logic [31:0] f_adds(input logic [3:0] d, n, m);
        return {7'b0111001, d, n, m, 13'b0};
    endfunction
    function automatic logic [31:0] f_sub(input logic [3:0] d, n, m);
        return {7'b0110010, d, n, m, 13'b0};
    endfunction
    function automatic logic [31:0] f_mov(input logic [3:0] d);
        return {7'b0000000, d, 21'b0};
    endfunction
    function automatic logic [31:0] f_subi(input logic [3:0] d);
        return {7'b0010010, d, d, 1'b0, 16'd1};
    endfunction
    function automatic logic [31:0] f_not(input logic [3:0] d);
        return {7'b0110110, d, d, 17'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input logic [31:0] o);
        logic [31:0] r;
        case (o[31:25])
            7'b0110001: rf[o[24:21]] = rf[o[20:17]] + rf[o[16:13]];
            7'b0111001: begin
                r = rf[o[20:17]] + rf[o[16:13]];
                rf[o[24:21]] = r;
                nf = r[31];
                zf = (r == 32'd0);
            end
            7'b0110010: rf[o[24:21]] = rf[o[20:17]] - rf[o[16:13]];
            7'b0000000: rf[o[24:21]] = {16'b0, o[15:0]};
            7'b0010010: rf[o[24:21]] = rf[o[20:17]] - {16'b0, o[15:0]};
            7'b0110110: rf[o[24:21]] = ~rf[o[20:17]];
            default: ;
        endcase
    endtask

    task automatic run(input logic [1:0] t, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [15:0] imm, input logic [31:0] rdat, input logic [3:0] fl,
                       input int stall_at);
        bus.mul_type = t;
        bus.dest_reg = rd;
        bus.source_reg = rs;
        bus.immediate = imm;
        bus.readDataSecond = rdat;
        bus.flags_in = fl;
        bus.start_mul = 1'b1;
        tick();
        bus.start_mul = 1'b0;
        bus.flags_in = 4'b0;
        nops = 0;
        while (bus.mux_ctrl && !bus.mul_release && nops < 120) begin
            ops[nops] = bus.output_instruction;
            exec(bus.output_instruction);
            if (nops == stall_at) begin
                bus.stall = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    chk("stall_hold_op", bus.output_instruction, ops[nops]);
                    chk("stall_busy", {31'b0, bus.busy}, 32'd1);
                end
                bus.stall = 1'b0;
            end
            nops++;
            tick();
        end
        chk("reached_done", {31'b0, bus.mul_release}, 32'd1);
        rel = bus.mul_release;
        fr = bus.flags_restore;
        fb = bus.flags_back_out;
        chk("done_mux", {31'b0, bus.mux_ctrl}, 32'd1);
        chk("done_op_nop", bus.output_instruction, NOP);
        tick();
        chk("idle_after_done", {30'b0, bus.busy, bus.mul_release}, 32'd0);
    endtask

    initial begin
        int dbl;
        for (int i = 0; i < 16; i++) rf[i] = 32'hDEAD_0000 + i;
        nf = 1'b0;
        zf = 1'b0;
        bus.start_mul = 1'b0;
        bus.mul_type = 2'd0;
        bus.dest_reg = 4'd0;
        bus.source_reg = 4'd0;
        bus.immediate = 16'd0;
        bus.readDataSecond = 32'd0;
        bus.flags_in = 4'd0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        repeat (3) tick();
        chk("rst_op", bus.output_instruction, NOP);
        chk("rst_outs", {25'b0, bus.mux_ctrl, bus.busy, bus.mul_release, bus.flags_restore, bus.mul_err, 1'b0},
            32'd0);
        chk("rst_fb", {28'b0, bus.flags_back_out}, 32'd0);
        rst = 1'b1;
        tick();

        rf[0] = 32'd7;
        run(2'd0, 4'd1, 4'd0, 16'd3, 32'd0, 4'b1010, -1);
        chk("muli3_n", nops, 6);
        chk("muli3_op0", ops[0], f_mov(4'd15));
        chk("muli3_op1", ops[1], f_add(4'd15, 4'd15, 4'd0));
        chk("muli3_op2", ops[2], f_mov(4'd1));
        chk("muli3_op3", ops[3], f_add(4'd1, 4'd1, 4'd15));
        chk("muli3_op4", ops[4], f_add(4'd15, 4'd15, 4'd15));
        chk("muli3_op5", ops[5], f_add(4'd1, 4'd1, 4'd15));
        chk("muli3_fr", {31'b0, fr}, 32'd1);
        chk("muli3_fb", {28'b0, fb}, 32'hA);
        chk("muli3_r1", rf[1], 32'd21);

        rf[3] = 32'd5;
        run(2'd2, 4'd2, 4'd3, 16'hFFFE, 32'd0, 4'b0011, -1);
        chk("mulsi_n", nops, 9);
        chk("mulsi_op5", ops[5], f_subi(4'd2));
        chk("mulsi_op6", ops[6], f_not(4'd2));
        chk("mulsi_op7", ops[7], f_sub(4'd15, 4'd15, 4'd15));
        chk("mulsi_op8", ops[8], f_adds(4'd2, 4'd2, 4'd15));
        chk("mulsi_r2", rf[2], 32'hFFFF_FFF6);
        chk("mulsi_nz", {30'b0, nf, zf}, 32'd2);
        chk("mulsi_fr", {31'b0, fr}, 32'd0);
        chk("mulsi_rel", {31'b0, rel}, 32'd1);

        run(2'd3, 4'd1, 4'd0, 16'd0, 32'd0, 4'b1111, -1);
        chk("mulsr0_n", nops, 3);
        chk("mulsr0_op0", ops[0], f_mov(4'd1));
        chk("mulsr0_op1", ops[1], f_sub(4'd15, 4'd15, 4'd15));
        chk("mulsr0_op2", ops[2], f_adds(4'd1, 4'd1, 4'd15));
        chk("mulsr0_r1", rf[1], 32'd0);
        chk("mulsr0_z", {31'b0, zf}, 32'd1);

        rf[4] = 32'd7;
        run(2'd1, 4'd4, 4'd4, 16'd0, 32'h8000_0000, 4'b0101, -1);
        chk("mulr_n", nops, 37);
        dbl = 0;
        for (int i = 3; i < 34; i++) if (ops[i] == f_add(4'd15, 4'd15, 4'd15)) dbl++;
        chk("mulr_dbl", dbl, 31);
        chk("mulr_op34", ops[34], f_add(4'd4, 4'd4, 4'd15));
        chk("mulr_op35", ops[35], f_subi(4'd4));
        chk("mulr_op36", ops[36], f_not(4'd4));
        chk("mulr_r4", rf[4], 32'h8000_0000);
        chk("mulr_fr", {31'b0, fr}, 32'd1);
        chk("mulr_fb", {28'b0, fb}, 32'h5);

        rf[0] = 32'd7;
        run(2'd0, 4'd1, 4'd0, 16'd5, 32'd0, 4'b0000, 3);
        chk("stall_n", nops, 7);
        chk("stall_op3", ops[3], f_add(4'd1, 4'd1, 4'd15));
        chk("stall_r1", rf[1], 32'd35);

        bus.mul_type = 2'd0;
        bus.dest_reg = 4'd1;
        bus.source_reg = 4'd0;
        bus.immediate = 16'd3;
        bus.start_mul = 1'b1;
        tick();
        bus.start_mul = 1'b0;
        tick();
        chk("flush_in_cpy", bus.output_instruction, f_add(4'd15, 4'd15, 4'd0));
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_idle", {29'b0, bus.mux_ctrl, bus.busy, bus.mul_release}, 32'd0);
        chk("flush_nop", bus.output_instruction, NOP);
        tick();
        chk("flush_stays_idle", {30'b0, bus.busy, bus.flags_restore}, 32'd0);

        bus.start_mul = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start_mul = 1'b0;
        bus.flush = 1'b0;
        chk("start_with_flush_ignored", {31'b0, bus.busy}, 32'd0);

        bus.dest_reg = 4'd15;
        bus.start_mul = 1'b1;
        tick();
        bus.start_mul = 1'b0;
        chk("err_pulse", {31'b0, bus.mul_err}, 32'd1);
        chk("err_no_issue", {30'b0, bus.mux_ctrl, bus.busy}, 32'd0);
        tick();
        chk("err_one_cycle", {31'b0, bus.mul_err}, 32'd0);
        bus.dest_reg = 4'd1;
        bus.source_reg = 4'd15;
        bus.start_mul = 1'b1;
        tick();
        bus.start_mul = 1'b0;
        chk("err_rs_pulse", {30'b0, bus.mul_err, bus.busy}, 32'd2);

        bus.mul_type = 2'd1;
        bus.dest_reg = 4'd4;
        bus.source_reg = 4'd4;
        bus.readDataSecond = 32'h8000_0000;
        bus.start_mul = 1'b1;
        tick();
        bus.start_mul = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b0;
        tick();
        chk("midrst_nop", bus.output_instruction, NOP);
        chk("midrst_idle", {30'b0, bus.mux_ctrl, bus.busy}, 32'd0);
        rst = 1'b1;
        tick();
        rf[0] = 32'd7;
        run(2'd0, 4'd1, 4'd0, 16'd3, 32'd0, 4'b0110, -1);
        chk("postrst_n", nops, 6);
        chk("postrst_r1", rf[1], 32'd21);
        chk("postrst_fb", {28'b0, fb}, 32'h6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
